// File: rtl/iic_axil_pkg.sv
// Shared types and constants for the IIC AXI4-Lite command master and its benches.
package iic_axil_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RD   = 3'd3,
        RDAT = 3'd4,
        RSP  = 3'd5
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // IIC controller register byte offsets
    localparam logic [8:0] CR      = 9'h100;
    localparam logic [8:0] SR      = 9'h104;
    localparam logic [8:0] TX_FIFO = 9'h108;
    localparam logic [8:0] RX_FIFO = 9'h10C;

endpackage

// File: rtl/iic_axil_timeout_cnt.sv
// Saturating stall counter; hit flags the edge on which the count reaches MAX.
module iic_axil_timeout_cnt #(
    parameter int MAX = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // Next count: clear wins, otherwise count up until saturated
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (en && (MAX > 0) && (cnt_r != CW'(MAX))) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // A MAX of zero disables the terminal flag entirely
    always_comb begin
        hit = 1'b0;
        if (MAX > 0) begin
            hit = (cnt_nxt_s == CW'(MAX));
        end else begin
            hit = 1'b0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/iic_axil_cmd_master.sv
// Single-outstanding AXI4-Lite master turning register write/read commands into
// AXI-Lite transactions on the IIC controller's slave port. All outputs are flops.
module iic_axil_cmd_master
    import iic_axil_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic                  timeout,
    output logic                  busy,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_e state_r;
    state_e state_nxt_s;

    logic aw_done_r;
    logic w_done_r;
    logic aw_done_nxt_s;
    logic w_done_nxt_s;

    logic accept_s;
    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic ar_hs_s;
    logic r_hs_s;
    logic rsp_hs_s;

    logic tmo_clr_s;
    logic tmo_en_s;
    logic tmo_hit_s;

    // Handshake decode; valids/readies are registered and state-exclusive
    always_comb begin
        accept_s = cmd_valid & cmd_ready;
        aw_hs_s  = m_axi_awvalid & m_axi_awready;
        w_hs_s   = m_axi_wvalid & m_axi_wready;
        b_hs_s   = m_axi_bvalid & m_axi_bready;
        ar_hs_s  = m_axi_arvalid & m_axi_arready;
        r_hs_s   = m_axi_rvalid & m_axi_rready;
        rsp_hs_s = rsp_valid & rsp_ready;
    end

    // Next-state logic; AW and W complete independently in WR
    always_comb begin
        state_nxt_s   = state_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                    state_nxt_s   = cmd_write ? WR : RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR: begin
                aw_done_nxt_s = aw_done_r | aw_hs_s;
                w_done_nxt_s  = w_done_r | w_hs_s;
                if (aw_done_nxt_s && w_done_nxt_s) begin
                    state_nxt_s = WB;
                end else begin
                    state_nxt_s = WR;
                end
            end
            WB: begin
                if (b_hs_s) begin
                    state_nxt_s = RSP;
                end else begin
                    state_nxt_s = WB;
                end
            end
            RD: begin
                if (ar_hs_s) begin
                    state_nxt_s = RDAT;
                end else begin
                    state_nxt_s = RD;
                end
            end
            RDAT: begin
                if (r_hs_s) begin
                    state_nxt_s = RSP;
                end else begin
                    state_nxt_s = RDAT;
                end
            end
            RSP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Stall counter runs in the slave-wait states and restarts on any progress
    always_comb begin
        tmo_en_s  = (state_r == WR) || (state_r == WB) ||
                    (state_r == RD) || (state_r == RDAT);
        tmo_clr_s = accept_s | aw_hs_s | w_hs_s | b_hs_s | ar_hs_s | r_hs_s;
    end

    iic_axil_timeout_cnt #(
        .MAX (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .clr   (tmo_clr_s),
        .en    (tmo_en_s),
        .hit   (tmo_hit_s)
    );

    // State and channel-completion registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
        end
    end

    // Control outputs are decoded from the next state so they align with it
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            cmd_ready     <= (state_nxt_s == IDLE);
            busy          <= (state_nxt_s != IDLE);
            m_axi_awvalid <= (state_nxt_s == WR) && !aw_done_nxt_s;
            m_axi_wvalid  <= (state_nxt_s == WR) && !w_done_nxt_s;
            m_axi_bready  <= (state_nxt_s == WB);
            m_axi_arvalid <= (state_nxt_s == RD);
            m_axi_rready  <= (state_nxt_s == RDAT);
            rsp_valid     <= (state_nxt_s == RSP);
            if (accept_s) begin
                timeout <= 1'b0;
            end else begin
                timeout <= timeout | tmo_hit_s;
            end
        end
    end

    // Command payload latch and response capture
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            m_axi_awaddr <= '0;
            m_axi_araddr <= '0;
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b00;
        end else begin
            if (accept_s) begin
                m_axi_awaddr <= cmd_addr;
                m_axi_araddr <= cmd_addr;
                m_axi_wdata  <= cmd_wdata;
                m_axi_wstrb  <= cmd_wstrb;
                rsp_write    <= cmd_write;
            end
            if (b_hs_s) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi_bresp;
            end else if (r_hs_s) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end
        end
    end

endmodule

// File: tb/tb_iic_axil_cmd_master.sv
// Directed + randomized bench: an in-bench AXI-Lite slave with per-transaction
// delays, and a reference register image updated from the command stream.
module tb_iic_axil_cmd_master;
    import iic_axil_pkg::*;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write, timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    iic_axil_cmd_master #(
        .ADDR_W (AW), .DATA_W (DW), .TIMEOUT_CYCLES (TMO)
    ) dut (
        .s_axi_aclk (clk), .s_axi_aresetn (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_resp (rsp_resp), .rsp_write (rsp_write), .timeout (timeout), .busy (busy),
        .m_axi_awaddr (m_axi_awaddr), .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
        .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready), .m_axi_bresp (m_axi_bresp), .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready), .m_axi_araddr (m_axi_araddr), .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready), .m_axi_rdata (m_axi_rdata), .m_axi_rresp (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid), .m_axi_rready (m_axi_rready)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-transaction configuration and results
    logic          t_write;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [SW-1:0] t_wstrb;
    logic [1:0]    t_resp;
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_hold;
    bit            keep_valid, exp_tmo;
    int            r_acc, r_aw_c, r_w_c;
    logic [DW-1:0] r_rdata;
    logic [63:0]   tmo_hist;

    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] slv_mem [8];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Runs one command to completion; entered and left just after a falling edge
    task automatic run_txn(input string tag);
        int cyc = 0, acc = -1, rsp_c = -1, exp_lat = 0;
        int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rsp_n = 0;
        int aw_wt = 0, w_wt = 0, b_wt = 0, ar_wt = 0, r_wt = 0, hold = 0;
        int prot = 0, bad_acc = 0, rel = 0;
        bit aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
        logic [AW-1:0] p_awaddr = '0, p_araddr = '0, g_awaddr = '0, g_araddr = '0;
        logic [DW-1:0] p_wdata = '0, g_wdata = '0, rsp_d = '0;
        logic [SW-1:0] g_wstrb = '0;
        logic [1:0]    rsp_r = 2'b00;
        logic          rsp_w = 1'b0, rsp_t = 1'b0;
        tmo_hist  = '0;
        cmd_valid = 1'b1; cmd_write = t_write; cmd_addr = t_addr;
        cmd_wdata = t_wdata; cmd_wstrb = t_wstrb;
        while (rsp_n == 0 && cyc < 300) begin
            if (acc >= 0 && !keep_valid) cmd_valid = 1'b0;
            if (acc < 0) begin
                if (cmd_ready && cmd_valid) acc = cyc;
            end else if (cmd_ready && cmd_valid) bad_acc++;
            rel = cyc - acc;
            if (acc >= 0 && rel < 64) tmo_hist[rel] = timeout;
            if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) prot++;
            if (w_pend && (!m_axi_wvalid || m_axi_wdata !== p_wdata)) prot++;
            if (ar_pend && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) prot++;
            m_axi_awready = m_axi_awvalid && (aw_wt >= aw_dly);
            m_axi_wready  = m_axi_wvalid && (w_wt >= w_dly);
            m_axi_arready = m_axi_arvalid && (ar_wt >= ar_dly);
            m_axi_bvalid  = (aw_n > 0) && (w_n > 0) && (b_n == 0) && (b_wt >= b_dly);
            m_axi_bresp   = t_resp;
            m_axi_rvalid  = (ar_n > 0) && (r_n == 0) && (r_wt >= r_dly);
            m_axi_rdata   = slv_mem[g_araddr[4:2]];
            m_axi_rresp   = t_resp;
            if (m_axi_bready && !((aw_n > 0) && (w_n > 0) && (b_n == 0))) prot++;
            if (m_axi_rready && !((ar_n > 0) && (r_n == 0))) prot++;
            if (rsp_valid && ((t_write && b_n == 0) || (!t_write && r_n == 0))) prot++;
            aw_pend = m_axi_awvalid && !m_axi_awready; p_awaddr = m_axi_awaddr;
            w_pend  = m_axi_wvalid && !m_axi_wready;   p_wdata  = m_axi_wdata;
            ar_pend = m_axi_arvalid && !m_axi_arready; p_araddr = m_axi_araddr;
            if (aw_pend) aw_wt++;
            if (w_pend) w_wt++;
            if (ar_pend) ar_wt++;
            if ((aw_n > 0) && (w_n > 0) && (b_n == 0) && !m_axi_bvalid) b_wt++;
            if ((ar_n > 0) && (r_n == 0) && !m_axi_rvalid) r_wt++;
            if (m_axi_awvalid && m_axi_awready) begin aw_n++; r_aw_c = cyc; g_awaddr = m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin
                w_n++; r_w_c = cyc; g_wdata = m_axi_wdata; g_wstrb = m_axi_wstrb;
            end
            if (m_axi_arvalid && m_axi_arready) begin ar_n++; g_araddr = m_axi_araddr; end
            if (m_axi_bvalid && m_axi_bready) begin
                b_n++;
                slv_mem[g_awaddr[4:2]] = merge(slv_mem[g_awaddr[4:2]], g_wdata, g_wstrb);
            end
            if (m_axi_rvalid && m_axi_rready) r_n++;
            if (rsp_valid) begin
                if (rsp_c < 0) begin
                    rsp_c = cyc; rsp_d = rsp_rdata; rsp_r = rsp_resp; rsp_w = rsp_write; rsp_t = timeout;
                end else if (rsp_rdata !== rsp_d || rsp_resp !== rsp_r || rsp_write !== rsp_w) prot++;
                rsp_ready = (hold >= rsp_hold);
                if (!rsp_ready) hold++;
                else rsp_n++;
            end else rsp_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid  = 1'b0; m_axi_rvalid = 1'b0; rsp_ready = 1'b0;
        if (!keep_valid) cmd_valid = 1'b0;
        chk({tag, ".done"}, rsp_n, 1);
        chk({tag, ".no_dup_rsp"}, rsp_valid, 1'b0);
        chk({tag, ".cmd_ready_back"}, cmd_ready, 1'b1);
        chk({tag, ".protocol"}, prot, 0);
        chk({tag, ".early_accept"}, bad_acc, 0);
        chk({tag, ".tmo_cleared"}, tmo_hist[1], 1'b0);
        chk({tag, ".tmo"}, rsp_t, exp_tmo);
        chk({tag, ".resp"}, rsp_r, t_resp);
        chk({tag, ".write_echo"}, rsp_w, t_write);
        if (t_write) begin
            exp_lat = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3;
            chk({tag, ".aw_n"}, aw_n, 1);
            chk({tag, ".w_n"}, w_n, 1);
            chk({tag, ".b_n"}, b_n, 1);
            chk({tag, ".ar_n"}, ar_n, 0);
            chk({tag, ".awaddr"}, g_awaddr, t_addr);
            chk({tag, ".wdata"}, g_wdata, t_wdata);
            chk({tag, ".wstrb"}, g_wstrb, t_wstrb);
            chk({tag, ".wr_rdata"}, rsp_d, 32'h0);
            ref_mem[t_addr[4:2]] = merge(ref_mem[t_addr[4:2]], t_wdata, t_wstrb);
        end else begin
            exp_lat = ar_dly + r_dly + 3;
            chk({tag, ".ar_n"}, ar_n, 1);
            chk({tag, ".aw_n"}, aw_n + w_n, 0);
            chk({tag, ".araddr"}, g_araddr, t_addr);
            chk({tag, ".rdata"}, rsp_d, ref_mem[t_addr[4:2]]);
        end
        chk({tag, ".latency"}, rsp_c - acc, exp_lat);
        r_acc   = acc;
        r_rdata = rsp_d;
    endtask

    task automatic set_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int awd, input int wd, input int bd, input int ard, input int rd,
                           input logic [1:0] rsp, input int hld, input bit kv, input bit et);
        t_write = w; t_addr = a; t_wdata = d; t_wstrb = 4'hF;
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
        t_resp = rsp; rsp_hold = hld; keep_valid = kv; exp_tmo = et;
    endtask

    int stale;

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        for (int i = 0; i < 8; i++) begin ref_mem[i] = 32'h0; slv_mem[i] = 32'h0; end
        ref_mem[1] = 32'h0000_00C0; slv_mem[1] = 32'h0000_00C0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.cmd_ready", cmd_ready, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 4'h0);
        chk("reset.readies", {m_axi_bready, m_axi_rready, timeout}, 3'h0);
        chk("reset.payload", {rsp_rdata, rsp_resp, rsp_write} | {m_axi_awaddr, m_axi_wstrb}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.cmd_ready", cmd_ready, 1'b1);

        set_txn(1'b1, CR, 32'h0000_0001, 0, 0, 0, 0, 0, OKAY, 0, 1'b0, 1'b0);
        run_txn("zero_wait_wr");
        chk("zero_wait_wr.aw_w_same_cycle", r_aw_c - r_w_c, 0);
        chk("zero_wait_wr.aw_cycle", r_aw_c - r_acc, 1);

        set_txn(1'b0, SR, 32'h0, 0, 0, 0, 0, 5, OKAY, 0, 1'b0, 1'b0);
        run_txn("rd_sr");
        chk("rd_sr.value", r_rdata, 32'h0000_00C0);

        set_txn(1'b1, TX_FIFO, 32'hA5A5_0101, 3, 0, 0, 0, 0, OKAY, 0, 1'b0, 1'b0);
        run_txn("skew_w_first");
        chk("skew_w_first.order", r_aw_c - r_w_c, 3);
        set_txn(1'b1, TX_FIFO, 32'h5A5A_0202, 0, 3, 1, 0, 0, EXOKAY, 0, 1'b0, 1'b0);
        run_txn("skew_aw_first");
        chk("skew_aw_first.order", r_w_c - r_aw_c, 3);

        set_txn(1'b1, CR, 32'h0000_00FF, 0, 0, 0, 0, 0, SLVERR, 4, 1'b1, 1'b0);
        run_txn("slverr_hold");
        set_txn(1'b0, CR, 32'h0, 0, 0, 0, 0, 0, OKAY, 0, 1'b0, 1'b0);
        run_txn("after_hold_rd");
        chk("after_hold_rd.immediate_accept", r_acc, 0);

        set_txn(1'b0, RX_FIFO, 32'h0, 0, 0, 0, 20, 0, OKAY, 0, 1'b0, 1'b1);
        run_txn("stall_ar");
        chk("stall_ar.tmo_before", tmo_hist[16], 1'b0);
        chk("stall_ar.tmo_at_16", tmo_hist[17], 1'b1);
        chk("stall_ar.tmo_sticky", timeout, 1'b1);
        set_txn(1'b1, TX_FIFO, 32'h1234_5678, 0, 0, 0, 0, 0, OKAY, 0, 1'b0, 1'b0);
        run_txn("post_tmo_wr");
        chk("post_tmo_wr.tmo_low", timeout, 1'b0);

        for (int i = 0; i < 40; i++) begin
            t_write  = 1'($urandom_range(0, 1));
            t_addr   = CR + 9'(4 * $urandom_range(0, 7));
            t_wdata  = $urandom;
            t_wstrb  = 4'($urandom_range(1, 15));
            aw_dly   = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
            b_dly    = $urandom_range(0, 4); ar_dly = $urandom_range(0, 4);
            r_dly    = $urandom_range(0, 4); rsp_hold = $urandom_range(0, 3);
            t_resp   = 2'($urandom_range(0, 3));
            keep_valid = 1'b0; exp_tmo = 1'b0;
            run_txn("rnd");
        end

        // Reset while a write address is outstanding
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = TX_FIFO; cmd_wdata = 32'hDEAD_BEEF;
        cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.awvalid_before", m_axi_awvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 4'h0);
        chk("rst_mid.ctrl", {cmd_ready, busy, timeout, m_axi_bready, m_axi_rready}, 5'h0);
        chk("rst_mid.awaddr", m_axi_awaddr, 9'h0);
        chk("rst_mid.wdata", m_axi_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.cmd_ready_first_edge", cmd_ready, 1'b1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || m_axi_awvalid || m_axi_wvalid || busy) stale++;
        end
        chk("rst_mid.no_stale", stale, 0);

        set_txn(1'b0, TX_FIFO, 32'h0, 0, 0, 0, 1, 1, OKAY, 0, 1'b0, 1'b0);
        run_txn("post_rst_rd");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/iic_axil_cmd_master.md
Name: iic_axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command stream (register write/read) into AXI-Lite transactions against the IIC controller register slave.
- Sits directly upstream of the IIC controller: its m_axi_* outputs connect to the controller's s_axi_* slave ports.
- Lets sequencers and firmware-less test logic program the IIC core without an AXI interconnect.

Parameters:
- ADDR_W, 9, AXI address width; matches the IIC register space.
- DATA_W, 32, AXI data width; fixed at 32, strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, cycles without slave progress before the timeout flag sets; 0 disables timeout.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  register byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  AXI BRESP/RRESP of the transaction
- rsp_write  out  1  echo of cmd_write
- timeout  out  1  sticky: slave stalled ≥ TIMEOUT_CYCLES in the current transaction
- busy  out  1  state != IDLE
- m_axi_awaddr / awvalid / awready  out / out / in  ADDR_W / 1 / 1  write address channel
- m_axi_wdata / wstrb / wvalid / wready  out / out / out / in  DATA_W / DATA_W/8 / 1 / 1  write data channel
- m_axi_bresp / bvalid / bready  in / in / out  2 / 1 / 1  write response channel
- m_axi_araddr / arvalid / arready  out / out / in  ADDR_W / 1 / 1  read address channel
- m_axi_rdata / rresp / rvalid / rready  in / in / in / out  DATA_W / 2 / 1 / 1  read data channel

Behaviour:
- One clock, s_axi_aclk. Reset is asynchronous, active-low (s_axi_aresetn).
- Reset values: all valid/ready outputs 0, cmd_ready 0, busy 0, timeout 0, addr/data/strb/rdata/rsp_resp/rsp_write 0, state IDLE.
- States:
  - IDLE: cmd_ready = 1. On accept, latch the command and clear timeout. Go to WR (cmd_write = 1) or RD.
  - WR: awvalid and wvalid both assert the cycle after accept. Each drops independently on its own handshake (aw_done / w_done flags). Either order and same-cycle completion are legal. When both are done, go to WB.
  - WB: bready = 1. On bvalid, capture bresp, set rsp_rdata = 0, go to RSP.
  - RD: arvalid = 1 until arready, then go to RDAT.
  - RDAT: rready = 1. On rvalid, capture rdata and rresp, go to RSP.
  - RSP: rsp_valid = 1, outputs stable until rsp_ready, then go to IDLE.
- cmd_ready is registered and is 0 outside IDLE, so no command is accepted during a transaction or while a response is held.
- AXI rules:
  - A valid never deasserts before its handshake. Payloads are stable while valid.
  - bready and rready are asserted only in WB and RDAT respectively.
  - No combinational path from any input to any output.
- Minimum latency, zero-wait slave:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: accept at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, rsp_valid at cycle 3.
- Timeout:
  - A counter resets on entry to each of WR, WB, RD, RDAT and on any handshake in those states.
  - It saturates at TIMEOUT_CYCLES, which sets timeout.
  - The transaction is not abandoned, since AXI forbids dropping valid. timeout stays 1 until the next command accept.
- rsp_resp is passed through unmodified; SLVERR/DECERR are not retried.
- Reset mid-transaction: all valids drop immediately on reset assertion. Any held command/response is discarded; no response is produced after reset.

Decomposition:
- Package iic_axil_pkg:
  - state enum (IDLE, WR, WB, RD, RDAT, RSP)
  - AXI resp constants (OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11)
  - IIC register offset constants used by benches (e.g. CR = 9'h100, SR = 9'h104, TX_FIFO = 9'h108, RX_FIFO = 9'h10C)
- Sub-module iic_axil_timeout_cnt: saturating counter with clear/enable inputs and a terminal flag. The rest stays in one FSM.

Test Plan:
- Zero-wait write: cmd write, addr 9'h100, data 32'h0000_0001, strb 4'hF. AW and W handshake in the same cycle with awaddr = 9'h100, wdata = 32'h1. rsp_valid at cycle 3 with rsp_resp = 2'b00, rsp_write = 1.
- Read: cmd read, addr 9'h104. Slave returns rdata 32'h0000_00C0 after 5 cycles of rvalid low. rsp_rdata = 32'hC0, rsp_resp = 2'b00, rready high only in RDAT.
- Skewed write channels, two runs:
  - wready high 3 cycles before awready: wvalid drops after its handshake, awvalid holds until its own.
  - Mirrored case: awready first.
  - Both runs must yield exactly one B wait and one response.
- Error and backpressure: slave bresp = 2'b10 → rsp_resp = 2'b10. Hold rsp_ready low for 4 cycles: rsp outputs stable, cmd_ready stays 0, a second cmd_valid is not accepted until after the rsp handshake.
- Timeout: TIMEOUT_CYCLES = 16, arready held low 20 cycles. timeout rises after 16 stalled cycles and arvalid stays high. On the next accept timeout clears to 0.
- Reset mid-transaction: assert s_axi_aresetn = 0 while awvalid = 1. All outputs drop asynchronously to reset values. After release, cmd_ready = 1 on the first clock edge and no stale rsp_valid appears.
